mutex_rr: RTL and testbench
===========================

MUTEX_RR -- requirements
Module: mutex_rr

Interface
REQ-001 The module SHALL have parameter N, default 4, meaning the number of requesters (legal 2..16).
REQ-002 The module SHALL have parameter GAP, default 0, meaning idle cycles inserted between owners (legal 0 or 1).
REQ-003 The module SHALL have parameter HOLD_MAX, default 0, meaning the maximum grant length in cycles before forced revoke (0 disables the limit; legal 0..255).
REQ-004 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 The module SHALL have port req, input, N bits, level requests; bit i high means requester i wants the resource.
REQ-007 The module SHALL have port gnt, output, N bits, registered one-hot (or zero) grant.
REQ-008 The module SHALL have port gnt_id, output, clog2(N) bits, index of the current owner; 0 when gnt is zero.
REQ-009 The module SHALL have port gnt_vld, output, 1 bit, high iff gnt is nonzero.
REQ-010 The module SHALL have port timeout, output, 1 bit, one-cycle pulse marking a forced revoke.

Function
REQ-011 gnt SHALL never have more than one bit set in any cycle, including at owner changes.
REQ-012 The FSM SHALL have states IDLE, OWN and GAPW (GAPW used only when GAP=1).
REQ-013 In IDLE, with any unmasked req bit high at an edge, the block SHALL select the winner and assert its gnt bit at that same edge (1-cycle latency from sampled req to gnt); state -> OWN.
REQ-014 Winner selection SHALL be round-robin: the first unmasked requester at or after ptr, scanning upward modulo N; ptr resets to 0.
REQ-015 On every grant, ptr SHALL be set to (owner+1) mod N.
REQ-016 In OWN, gnt SHALL stay constant while req[owner] stays high and no revoke occurs; other requests SHALL not affect gnt.
REQ-017 In OWN, when req[owner] is sampled low with GAP=0, gnt SHALL switch directly to the next round-robin winner at that edge if one exists, else clear to zero and return to IDLE.
REQ-018 In OWN, when req[owner] is sampled low with GAP=1, gnt SHALL clear at that edge, the FSM SHALL spend exactly one cycle in GAPW, then behave as IDLE.
REQ-019 With HOLD_MAX>0, an 8-bit hold counter SHALL load 1 on grant and increment each cycle in OWN, saturating at 255.
REQ-020 When the counter equals HOLD_MAX, req[owner] is still high, and another unmasked request is pending, the block SHALL revoke: pulse timeout for one cycle, set mask[owner], and hand over per REQ-017/REQ-018.
REQ-021 No revoke SHALL occur if no other unmasked request is pending; the owner keeps the grant indefinitely.
REQ-022 mask[i] SHALL clear on the first edge where req[i] is sampled low; a masked requester is never granted.
REQ-023 If req[owner] drops at the same edge the revoke condition is met, the event SHALL be treated as a normal release: no timeout pulse, no mask set.
REQ-024 Requests that rise and fall between edges SHALL be ignored; only sampled levels count.
REQ-025 gnt_id and gnt_vld SHALL be registered and consistent with gnt in every cycle.

Reset
REQ-026 While reset is high, gnt, gnt_id, gnt_vld and timeout SHALL be 0 immediately (asynchronously), with state=IDLE, ptr=0, mask=0, counter=0.
REQ-027 Reset asserted mid-grant SHALL drop gnt without waiting for a clock; after deassertion the first grant SHALL follow REQ-013 from ptr=0.

Verification
REQ-028 N=4, GAP=0: req=4'b1010 at edge 1 -> gnt=4'b0010, gnt_id=1 after edge 1; ptr=2.
REQ-029 N=4, GAP=0: owner 1, req drops to 4'b1000 -> gnt=4'b1000 at the same edge, with no zero cycle; then req=4'b0011 after release -> gnt=4'b0001 (wraps from ptr=0).
REQ-030 N=4, GAP=1: owner 0 releases with req[2] high -> one cycle gnt=0, then gnt=4'b0100.
REQ-031 HOLD_MAX=8: req[0] high alone for 20 cycles -> no timeout; req[3] rises at cycle 20 -> timeout pulse, gnt=4'b1000 next edge; req[0] stays high and is not regranted until it drops and re-rises.
REQ-032 Reset asserted at mid-cycle during a grant -> gnt=0 before the next edge; random req traffic for 10k cycles -> gnt never multi-hot, and every continuously held request is granted within N grants.

Source files
------------

// File: rtl/mutex_rr.sv
// Round-robin mutex arbiter: grants a single shared resource to one of N
// level requesters. Supports an optional idle gap between owners and an
// optional hold limit that forcibly revokes a long-running owner when
// someone else is waiting. All outputs are registered.

// Per-requester mask lane: a revoked requester stays masked until it is
// sampled low, so it cannot immediately win the resource back.
module mutex_rr_lane (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic set_mask,
    output logic cand
);
    logic mask;

    // Mask is set on revoke and clears on the first edge the request is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mask <= 1'b0;
        else       mask <= set_mask | (mask & req);
    end

    assign cand = req & ~mask;
endmodule

module mutex_rr #(
    parameter int N        = 4,
    parameter int GAP      = 0,
    parameter int HOLD_MAX = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 gnt_vld,
    output logic                 timeout
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {IDLE, OWN, GAPW} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [N-1:0]    gnt_d;
    logic [IW-1:0]   id_d;
    logic            vld_d, tmo_d;

    logic [N-1:0]    cand;
    logic [N-1:0]    set_mask;
    logic [N-1:0]    pool;
    logic [IW:0]     pick;
    logic            win_vld;
    logic [IW-1:0]   win_id;
    logic [N-1:0]    win_oh;
    logic            own_req, others, revoke;

    for (genvar i = 0; i < N; i++) begin : g_lane
        mutex_rr_lane u_lane (
            .clk      (clk),
            .reset    (reset),
            .req      (req[i]),
            .set_mask (set_mask[i]),
            .cand     (cand[i])
        );
    end

    // First set bit of pool at or after start, scanning upward modulo N.
    // Walking downward and overwriting leaves the smallest offset as winner.
    function automatic logic [IW:0] rr_pick(input logic [N-1:0] vec,
                                            input logic [IW-1:0] start);
        logic [IW:0] r;
        int j;
        r = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(start) + k;
            if (j >= N) j = j - N;
            if (vec[IW'(j)]) r = {1'b1, IW'(j)};
        end
        return r;
    endfunction

    // Candidate pool excludes the current owner, which covers both the
    // release case (owner's req already low) and the revoke case.
    always_comb begin
        pool    = cand & ~gnt;
        pick    = rr_pick(pool, ptr_q);
        win_vld = pick[IW];
        win_id  = pick[IW-1:0];
        win_oh  = N'(1) << win_id;
        own_req = |(req & gnt);
        others  = |pool;
        revoke  = (HOLD_MAX > 0) && (state_q == OWN) && own_req && others &&
                  (int'(cnt_q) >= HOLD_MAX);
    end

    // Next-state and next-output logic; holds everything by default.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt;
        id_d     = gnt_id;
        vld_d    = gnt_vld;
        tmo_d    = 1'b0;
        set_mask = '0;

        case (state_q)
            // The gap cycle arbitrates exactly like idle at its closing edge.
            IDLE, GAPW: begin
                state_d = IDLE;
                if (win_vld) begin
                    state_d = OWN;
                    gnt_d   = win_oh;
                    id_d    = win_id;
                    vld_d   = 1'b1;
                    ptr_d   = (win_id == IW'(N - 1)) ? '0 : win_id + 1'b1;
                    cnt_d   = 8'd1;
                end
            end
            OWN: begin
                if (!own_req || revoke) begin
                    if (revoke) begin
                        tmo_d    = 1'b1;
                        set_mask = gnt;
                    end
                    if (GAP == 0 && win_vld) begin
                        gnt_d = win_oh;
                        id_d  = win_id;
                        vld_d = 1'b1;
                        ptr_d = (win_id == IW'(N - 1)) ? '0 : win_id + 1'b1;
                        cnt_d = 8'd1;
                    end else begin
                        state_d = (GAP == 0) ? IDLE : GAPW;
                        gnt_d   = '0;
                        id_d    = '0;
                        vld_d   = 1'b0;
                        cnt_d   = 8'd0;
                    end
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, hold counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= 8'd0;
            gnt     <= '0;
            gnt_id  <= '0;
            gnt_vld <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            gnt_id  <= id_d;
            gnt_vld <= vld_d;
            timeout <= tmo_d;
        end
    end
endmodule

// File: tb/tb_mutex_rr.sv
// Bench for mutex_rr: three instances (GAP=0, GAP=1, HOLD_MAX=8) share one
// request bus; a queue-free behavioural model per instance predicts owner,
// pointer and mask from the arbitration rules, and directed literals pin it.
module tb_mutex_rr;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] gnt_w [3];
    logic [1:0]   id_w  [3];
    logic         vld_w [3];
    logic         tmo_w [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mutex_rr #(.N(4), .GAP(0), .HOLD_MAX(0)) u_g0 (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt_w[0]),
        .gnt_id(id_w[0]), .gnt_vld(vld_w[0]), .timeout(tmo_w[0]));
    mutex_rr #(.N(4), .GAP(1), .HOLD_MAX(0)) u_g1 (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt_w[1]),
        .gnt_id(id_w[1]), .gnt_vld(vld_w[1]), .timeout(tmo_w[1]));
    mutex_rr #(.N(4), .GAP(0), .HOLD_MAX(8)) u_h8 (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt_w[2]),
        .gnt_id(id_w[2]), .gnt_vld(vld_w[2]), .timeout(tmo_w[2]));

    // ---------------- behavioural model ----------------
    int cfg_gap  [3] = '{0, 1, 0};
    int cfg_hold [3] = '{0, 0, 8};
    int m_owner  [3];
    int m_ptr    [3];
    int m_cnt    [3];
    bit m_tmo    [3];
    bit m_mask   [3][N];

    task automatic model_pick(input int k, input logic [N-1:0] r);
        for (int off = 0; off < N; off++) begin
            int i;
            i = (m_ptr[k] + off) % N;
            if (r[i] && !m_mask[k][i]) begin
                m_owner[k] = i;
                m_ptr[k]   = (i + 1) % N;
                m_cnt[k]   = 1;
                return;
            end
        end
    endtask

    task automatic model_step(input int k, input logic [N-1:0] r);
        bit give_up, rvk, others;
        give_up  = 0;
        rvk      = 0;
        m_tmo[k] = 0;
        if (m_owner[k] >= 0) begin
            others = 0;
            for (int i = 0; i < N; i++)
                if (i != m_owner[k] && r[i] && !m_mask[k][i]) others = 1;
            if (!r[m_owner[k]]) give_up = 1;
            else if (cfg_hold[k] > 0 && m_cnt[k] >= cfg_hold[k] && others) begin
                rvk = 1;
                give_up = 1;
            end
            if (!give_up && m_cnt[k] < 255) m_cnt[k]++;
        end
        if (rvk) begin
            m_tmo[k] = 1;
            m_mask[k][m_owner[k]] = 1;
        end
        for (int i = 0; i < N; i++) if (!r[i]) m_mask[k][i] = 0;
        if (give_up) begin
            m_owner[k] = -1;
            m_cnt[k]   = 0;
            if (cfg_gap[k] == 0) model_pick(k, r);
        end else if (m_owner[k] < 0) begin
            model_pick(k, r);
        end
    endtask

    // Model advances on the same edges as the DUTs; reset is immediate.
    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                m_owner[k] = -1;
                m_ptr[k]   = 0;
                m_cnt[k]   = 0;
                m_tmo[k]   = 0;
                for (int i = 0; i < N; i++) m_mask[k][i] = 0;
            end else begin
                model_step(k, req);
            end
        end
    end

    function automatic logic [N-1:0] exp_gnt(input int k);
        return (m_owner[k] < 0) ? '0 : (N'(1) << m_owner[k]);
    endfunction

    // ---------------- checking ----------------
    int           wait_n [2][N];
    logic [N-1:0] prev_g [2];

    task automatic clear_wait();
        for (int k = 0; k < 2; k++) begin
            prev_g[k] = '0;
            for (int i = 0; i < N; i++) wait_n[k][i] = 0;
        end
    endtask

    task automatic compare_all(input logic [N-1:0] r);
        logic [7:0] act, exp;
        for (int k = 0; k < 3; k++) begin
            act = {gnt_w[k], id_w[k], vld_w[k], tmo_w[k]};
            exp = {exp_gnt(k), (m_owner[k] < 0) ? 2'd0 : 2'(m_owner[k]),
                   m_owner[k] >= 0, m_tmo[k]};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL model_cmp inst=%0d t=%0t gnt/id/vld/tmo got=%b want=%b",
                         k, $time, act, exp);
            end
            checks++;
            if (!$onehot0(gnt_w[k])) begin
                errors++;
                $display("FAIL onehot inst=%0d t=%0t gnt=%b want at most one bit",
                         k, $time, gnt_w[k]);
            end
        end
        // Round-robin fairness: a held request sees at most N-1 other grants.
        for (int k = 0; k < 2; k++) begin
            bit newg;
            newg = (gnt_w[k] != '0) && (gnt_w[k] != prev_g[k]);
            for (int i = 0; i < N; i++) begin
                if (!r[i] || gnt_w[k][i]) wait_n[k][i] = 0;
                else if (newg) begin
                    wait_n[k][i]++;
                    checks++;
                    if (wait_n[k][i] > N - 1) begin
                        errors++;
                        $display("FAIL starve inst=%0d req=%0d other_grants=%0d want<=%0d",
                                 k, i, wait_n[k][i], N - 1);
                    end
                end
            end
            prev_g[k] = gnt_w[k];
        end
    endtask

    // Apply a request vector, let one edge sample it, then check.
    task automatic step(input logic [N-1:0] r);
        req = r;
        @(posedge clk);
        #2;
        compare_all(r);
    endtask

    // Literal expectation against both the DUT and the model.
    task automatic pin(input string name, input int k, input logic [N-1:0] g,
                       input logic [1:0] id, input logic t);
        checks++;
        if ({gnt_w[k], id_w[k], tmo_w[k]} !== {g, id, t}) begin
            errors++;
            $display("FAIL %s inst=%0d dut gnt/id/tmo got=%b/%0d/%b want=%b/%0d/%b",
                     name, k, gnt_w[k], id_w[k], tmo_w[k], g, id, t);
        end
        checks++;
        if (exp_gnt(k) !== g) begin
            errors++;
            $display("FAIL %s_model inst=%0d model gnt got=%b want=%b",
                     name, k, exp_gnt(k), g);
        end
    endtask

    initial begin
        logic [N-1:0] r;
        reset = 1'b1;
        req   = '0;
        clear_wait();
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++) pin("reset_state", k, 4'b0000, 2'd0, 1'b0);
        reset = 1'b0;

        // Round-robin pick, direct handover, wrap from ptr=0
        step(4'b1010); pin("rr_first",        0, 4'b0010, 2'd1, 1'b0);
        step(4'b1010); pin("hold_stable",     0, 4'b0010, 2'd1, 1'b0);
        step(4'b1000); pin("direct_handover", 0, 4'b1000, 2'd3, 1'b0);
                       pin("gap_release",     1, 4'b0000, 2'd0, 1'b0);
        step(4'b0000); pin("release_idle",    0, 4'b0000, 2'd0, 1'b0);
        step(4'b0011); pin("wrap_ptr0",       0, 4'b0001, 2'd0, 1'b0);
        step(4'b0000);

        // Idle gap between owners
        step(4'b0000);
        step(4'b0001); pin("gap_owner0",      1, 4'b0001, 2'd0, 1'b0);
        step(4'b0100); pin("gap_cycle",       1, 4'b0000, 2'd0, 1'b0);
                       pin("nogap_switch",    0, 4'b0100, 2'd2, 1'b0);
        step(4'b0100); pin("gap_then_grant",  1, 4'b0100, 2'd2, 1'b0);
        step(4'b0000);
        step(4'b0000);

        // Hold limit: lone owner keeps grant, contention forces revoke
        repeat (20) step(4'b0001);
        pin("lone_no_timeout", 2, 4'b0001, 2'd0, 1'b0);
        step(4'b1001); pin("timeout_revoke",  2, 4'b1000, 2'd3, 1'b1);
                       pin("no_limit_keeps",  0, 4'b0001, 2'd0, 1'b0);
        step(4'b1001); pin("timeout_pulse1",  2, 4'b1000, 2'd3, 1'b0);
        step(4'b1001);
        step(4'b1001); pin("masked_hold",     2, 4'b1000, 2'd3, 1'b0);
        step(4'b0001); pin("masked_no_grant", 2, 4'b0000, 2'd0, 1'b0);
        step(4'b0001); pin("masked_still",    2, 4'b0000, 2'd0, 1'b0);
        step(4'b0000);
        step(4'b0001); pin("regrant_after",   2, 4'b0001, 2'd0, 1'b0);
        repeat (9) step(4'b0001);
        step(4'b1000); pin("drop_same_edge",  2, 4'b1000, 2'd3, 1'b0);
        step(4'b0000);

        // Asynchronous reset in the middle of a grant
        step(4'b0010); pin("pre_reset",       0, 4'b0010, 2'd1, 1'b0);
        #1 reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) pin("async_reset", k, 4'b0000, 2'd0, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        clear_wait();
        step(4'b1010); pin("post_reset_ptr0", 0, 4'b0010, 2'd1, 1'b0);

        // Random traffic against the model
        r = req;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) r[i] = ~r[i];
            step(r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
